// File: rtl/basys_btn_pkg.sv
// -----------------------------------------------------------------------------
// basys_btn_pkg
// Shared constants for the Basys pushbutton conditioner: the number of buttons
// and the bit index of each physical button within the 5-bit button vectors.
// A small width helper used to size the optional auto-repeat counters also
// lives here.
// -----------------------------------------------------------------------------
package basys_btn_pkg;

   localparam int NUM_BTN = 5;

   localparam int BTN_U = 0;
   localparam int BTN_D = 1;
   localparam int BTN_L = 2;
   localparam int BTN_R = 3;
   localparam int BTN_C = 4;

   // Bits needed to hold values 0..max_val, never less than one bit.
   function automatic int bits_for(input int max_val);
      if (max_val < 2) begin
         return 1;
      end
      return $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One-bit button conditioner: two-flop synchronizer, saturating disagreement
// counter, debounced level and a one-cycle press strobe.
//
// Parameters
//   DEBOUNCE_CYCLES  cycles a new synchronized level must persist (>= 1)
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_raw    in   raw asynchronous button input
//   btn_level  out  debounced level, 1 = pressed
//   btn_pulse  out  high for the first cycle btn_level reads 1
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_raw,
   output logic btn_level,
   output logic btn_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   // The counter reaches at most DEBOUNCE_CYCLES-1 before it is cleared, so it
   // can never wrap.
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic          level_q, level_d;
   logic          pulse_q, pulse_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      level_d = level_q;
      pulse_d = 1'b0;
      cnt_d   = '0;
      // The counter holds the number of disagreement cycles already seen; on
      // the edge that completes DEBOUNCE_CYCLES of them the level is accepted.
      // The press strobe is registered alongside the level so both change on
      // the same edge.
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            pulse_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         pulse_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
         cnt_q   <= cnt_d;
      end
   end

   assign btn_level = level_q;
   assign btn_pulse = pulse_q;

endmodule

// File: rtl/basys_btn_cond.sv
// -----------------------------------------------------------------------------
// basys_btn_cond
// Conditions the five Basys pushbuttons (U, D, L, R, C) into debounced levels
// and one-cycle press strobes for the combo-lock FSM.
//
// Optional feature: define BASYS_BTN_REPEAT_EN to add auto-repeat for the
// buttons selected by REPEAT_MASK. While such a button stays pressed an extra
// strobe appears REPEAT_DELAY cycles after the press strobe and then every
// REPEAT_PERIOD cycles. Without the macro no repeat logic exists and the
// REPEAT_* parameters have no effect.
//
// Parameters
//   DEBOUNCE_CYCLES  debounce persistence in cycles (>= 1)
//   REPEAT_DELAY     press strobe to first repeat strobe (>= 1)
//   REPEAT_PERIOD    spacing of later repeat strobes (>= 1)
//   REPEAT_MASK      buttons eligible for auto-repeat (default L and R)
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   btn_raw    in   [4:0] raw buttons, bit0 U, bit1 D, bit2 L, bit3 R, bit4 C
//   btn_level  out  [4:0] debounced levels, 1 = pressed
//   btn_pulse  out  [4:0] one-cycle press (and repeat) strobes
// -----------------------------------------------------------------------------
module basys_btn_cond
   import basys_btn_pkg::*;
#(
   parameter int                  DEBOUNCE_CYCLES = 1000000,
   parameter int                  REPEAT_DELAY    = 50000000,
   parameter int                  REPEAT_PERIOD   = 10000000,
   parameter logic [NUM_BTN-1:0]  REPEAT_MASK     = NUM_BTN'((1 << BTN_L) | (1 << BTN_R))
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_pulse
);

   logic [NUM_BTN-1:0] press_pulse;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk       (clk),
         .rst_n     (rst_n),
         .btn_raw   (btn_raw[g]),
         .btn_level (btn_level[g]),
         .btn_pulse (press_pulse[g])
      );
   end

`ifdef BASYS_BTN_REPEAT_EN
   localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW      = bits_for(REP_MAX - 1);
   localparam logic [RW-1:0] DELAY_LOAD  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PERIOD_LOAD = RW'(REPEAT_PERIOD - 1);

   logic [NUM_BTN-1:0][RW-1:0] rep_cnt_q, rep_cnt_d;
   logic [NUM_BTN-1:0]         armed_q, armed_d;
   logic [NUM_BTN-1:0]         rep_pulse;

   // Each repeat counter counts down to the next repeat strobe. It is loaded
   // on the edge after the press strobe, so a count of zero falls exactly
   // REPEAT_DELAY (then REPEAT_PERIOD) cycles after the previous strobe.
   // Releasing the button disarms and clears the counter at once, so a later
   // press always starts again from REPEAT_DELAY.
   always_comb begin
      rep_cnt_d = rep_cnt_q;
      armed_d   = armed_q;
      rep_pulse = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
         rep_pulse[i] = REPEAT_MASK[i] & armed_q[i] & btn_level[i] & (rep_cnt_q[i] == '0);
         if (!REPEAT_MASK[i] || !btn_level[i]) begin
            armed_d[i]   = 1'b0;
            rep_cnt_d[i] = '0;
         end else if (press_pulse[i]) begin
            armed_d[i]   = 1'b1;
            rep_cnt_d[i] = DELAY_LOAD;
         end else if (armed_q[i]) begin
            rep_cnt_d[i] = rep_pulse[i] ? PERIOD_LOAD : rep_cnt_q[i] - 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rep_cnt_q <= '0;
         armed_q   <= '0;
      end else begin
         rep_cnt_q <= rep_cnt_d;
         armed_q   <= armed_d;
      end
   end

   assign btn_pulse = press_pulse | rep_pulse;
`else
   // Repeat disabled: the REPEAT_* parameters are deliberately unused.
   localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD + int'(REPEAT_MASK);

   assign btn_pulse = press_pulse;
`endif

endmodule

// File: doc/basys_btn_cond.md
BASYS_BTN_COND -- requirements
Module: basys_btn_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, sampled cycles a new level must persist before acceptance (legal range >= 1).
REQ-002 Parameter REPEAT_DELAY, default 50000000, cycles from press pulse to first auto-repeat pulse (>= 1).
REQ-003 Parameter REPEAT_PERIOD, default 10000000, cycles between subsequent auto-repeat pulses (>= 1).
REQ-004 Parameter REPEAT_MASK, default 5'b01100, buttons eligible for auto-repeat (L, R).
REQ-005 clk  input  1  single system clock; all state updates on rising edge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 btn_raw  input  5  raw asynchronous pushbuttons: bit0 U, bit1 D, bit2 L, bit3 R, bit4 C.
REQ-008 btn_level  output  5  debounced button level, 1 = pressed.
REQ-009 btn_pulse  output  5  one-cycle press strobe per button, consumed by the combo-lock FSM.

Function
REQ-010 Each bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-011 Per bit, the counter SHALL clear whenever the synchronized value equals btn_level, and increment otherwise.
REQ-012 btn_level SHALL take the synchronized value on the edge where the disagreement has lasted DEBOUNCE_CYCLES consecutive cycles; the counter clears on the same edge.
REQ-013 Latency from a clean raw transition to btn_level change: exactly 2 + DEBOUNCE_CYCLES clock cycles.
REQ-014 Disagreement shorter than DEBOUNCE_CYCLES (glitch, bounce) SHALL produce no btn_level or btn_pulse activity.
REQ-015 btn_pulse[i] SHALL be high for exactly the first cycle in which btn_level[i] reads 1; release (1->0) produces no pulse.
REQ-016 Buttons SHALL be fully independent; simultaneous presses yield simultaneous pulses on the same cycle.
REQ-017 The counter width SHALL be $clog2(DEBOUNCE_CYCLES+1) and SHALL never wrap.

Reset
REQ-018 While rst_n is low: synchronizers, counters, btn_level, btn_pulse and repeat state SHALL be 0, asynchronously.
REQ-019 After rst_n deasserts with a button already held, it SHALL be treated as a new press: pulse after 2 + DEBOUNCE_CYCLES cycles.
REQ-020 Reset asserted mid-debounce or mid-repeat SHALL discard all progress; no pulse is emitted for that interval.

Configuration
REQ-021 Macro BASYS_BTN_REPEAT_EN compiled in: for bits set in REPEAT_MASK, while btn_level stays 1, a btn_pulse SHALL occur REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles.
REQ-022 With BASYS_BTN_REPEAT_EN, release (btn_level 1->0) SHALL stop repeats immediately and reset the repeat counter; the next press restarts at REPEAT_DELAY.
REQ-023 Without BASYS_BTN_REPEAT_EN: no repeat counters are synthesized, REPEAT_* parameters are ignored, exactly one pulse per press.

Structure
REQ-024 Package basys_btn_pkg SHALL hold NUM_BTN = 5 and index constants BTN_U=0, BTN_D=1, BTN_L=2, BTN_R=3, BTN_C=4.
REQ-025 Sub-module btn_debounce (one bit: sync, counter, level, edge strobe) SHALL be instantiated NUM_BTN times via generate; repeat logic sits in basys_btn_cond.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3)
REQ-026 Reset: rst_n=0 with btn_raw=5'b11111 -> btn_level=0, btn_pulse=0; release rst_n -> all five pulses together exactly 6 cycles later.
REQ-027 Clean press of btnC held 20 cycles -> btn_level[4] rises 6 cycles after raw edge, btn_pulse[4] high 1 cycle; no pulse on release (repeat macro off).
REQ-028 Bounce: btnL toggles 1,0,1,0 each for 2 cycles then stable 1 -> exactly one btn_pulse[2], 6 cycles after the stable edge.
REQ-029 Glitch: btnU high for 3 cycles -> no btn_level or btn_pulse change.
REQ-030 Repeat (macro on): btnR held 20 cycles after press pulse -> pulses at +0, +8, +11, +14, +17, +20; btnC held same time -> single pulse.
REQ-031 Reset mid-hold: assert rst_n low 2 cycles after btnR press pulse, release with btnR still held -> one new pulse 6 cycles after release, repeat timing restarts.
